// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared pixel width, frame defaults and state encoding for the column feeder
package feeder_pkg;

  localparam int BIT_LENGTH = 5;
  localparam int DEF_IMG_W  = 8;
  localparam int DEF_IMG_H  = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/row_delay_line.sv
// rtl/row_delay_line.sv - one image row of pixel storage, read-before-write at a single address
module row_delay_line
  import feeder_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [BIT_LENGTH-1:0] i_din,
  output logic [BIT_LENGTH-1:0] o_dout
);

  logic [BIT_LENGTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
  end

  // Combinational read returns the old entry in the same cycle it is overwritten.
  assign o_dout = r_mem[i_addr];

endmodule

// File: rtl/window_col_feeder.sv
// rtl/window_col_feeder.sv - turns a raster pixel stream into 3-row columns for a vertical filter
module window_col_feeder
  import feeder_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIT_LENGTH-1:0] pixel_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIT_LENGTH-1:0] pixel_out1,
  output logic [BIT_LENGTH-1:0] pixel_out2,
  output logic [BIT_LENGTH-1:0] pixel_out3,
  output logic                  enable,
  output logic                  done,
  output logic                  error
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILLD = RW'(1);

  feeder_state_t r_state, w_next;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [BIT_LENGTH-1:0] r_out1, r_out2, r_out3;
  logic [BIT_LENGTH-1:0] w_lb0, w_lb1;
  logic r_enable, r_done, r_error;
  logic w_in_ready, w_accept, w_col_last, w_start_ok, w_streaming;

  assign w_in_ready  = (r_state == S_FILL) || (r_state == S_STREAM);
  assign w_accept    = in_valid && w_in_ready;
  assign w_col_last  = (r_col == COL_LAST);
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_streaming = (r_state == S_STREAM);

  // lb1 holds row r-1, lb0 holds row r-2; lb1's old entry shifts down into lb0.
  row_delay_line #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk(clk), .reset_n(reset_n), .i_we(w_accept), .i_addr(r_col),
    .i_din(pixel_in), .o_dout(w_lb1)
  );

  row_delay_line #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk(clk), .reset_n(reset_n), .i_we(w_accept), .i_addr(r_col),
    .i_din(w_lb1), .o_dout(w_lb0)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_FILL;
      S_FILL:         if (w_accept && w_col_last && (r_row == ROW_FILLD)) w_next = S_STREAM;
      // Any gap while streaming would break the enable burst, so the frame is abandoned.
      S_STREAM:       if (!in_valid || (w_col_last && (r_row == ROW_LAST))) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_out1   <= '0;
      r_out2   <= '0;
      r_out3   <= '0;
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      if (w_start_ok) begin
        r_col   <= '0;
        r_row   <= '0;
        r_error <= 1'b0;
      end
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_accept && w_streaming) begin
        r_out1   <= w_lb0;
        r_out2   <= w_lb1;
        r_out3   <= pixel_in;
        r_enable <= 1'b1;
        r_done   <= w_col_last && (r_row == ROW_LAST);
      end
      if (w_streaming && !in_valid) r_error <= 1'b1;
    end
  end

  assign in_ready   = w_in_ready;
  assign pixel_out1 = r_out1;
  assign pixel_out2 = r_out2;
  assign pixel_out3 = r_out3;
  assign enable     = r_enable;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_window_col_feeder.sv
// tb/tb_window_col_feeder.sv - scoreboard bench for window_col_feeder with 4x3 and 4x5 frames
module tb_window_col_feeder;

  localparam int W = 4;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] c;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] pixel_in = '0;
  int         sel = 0;

  logic       start3, start5, valid3, valid5;
  logic       rdy3, en3, done3, err3, rdy5, en5, done5, err5;
  logic [4:0] o1_3, o2_3, o3_3, o1_5, o2_5, o3_5;
  logic       prev3 = 1'b0, prev5 = 1'b0;

  exp_t       q3[$];
  exp_t       q5[$];
  logic [4:0] pix[5][W];
  int         n_checks = 0;
  int         n_fail = 0;

  assign start3 = start && (sel == 0);
  assign start5 = start && (sel == 1);
  assign valid3 = in_valid && (sel == 0);
  assign valid5 = in_valid && (sel == 1);

  always #5 clk = ~clk;

  window_col_feeder #(.IMG_W(W), .IMG_H(3)) u_h3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .pixel_in(pixel_in),
    .in_valid(valid3), .in_ready(rdy3), .pixel_out1(o1_3), .pixel_out2(o2_3),
    .pixel_out3(o3_3), .enable(en3), .done(done3), .error(err3)
  );

  window_col_feeder #(.IMG_W(W), .IMG_H(5)) u_h5 (
    .clk(clk), .reset_n(reset_n), .start(start5), .pixel_in(pixel_in),
    .in_valid(valid5), .in_ready(rdy5), .pixel_out1(o1_5), .pixel_out2(o2_5),
    .pixel_out3(o3_5), .enable(en5), .done(done5), .error(err5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] outs_sel();
    if (sel == 0) return {rdy3, o1_3, o2_3, o3_3, en3, done3, err3};
    return {rdy5, o1_5, o2_5, o3_5, en5, done5, err5};
  endfunction

  function automatic int qsize();
    return (sel == 0) ? q3.size() : q5.size();
  endfunction

  task automatic mon(input int id, input logic en, input logic dn,
                     input logic [14:0] outs, input logic prev_en);
    exp_t e;
    int   sz;
    sz = (id == 0) ? q3.size() : q5.size();
    if (en) begin
      if (sz == 0) begin
        check($sformatf("spurious_enable_%0d", id), {31'd0, en}, 32'd0);
      end else begin
        e = (id == 0) ? q3.pop_front() : q5.pop_front();
        check($sformatf("column_%0d", id), {outs, dn}, e);
      end
    end else begin
      if (dn) check($sformatf("done_without_enable_%0d", id), {31'd0, dn}, 32'd0);
      if (prev_en && sz != 0) check($sformatf("burst_break_%0d", id), sz, 0);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon(0, en3, done3, {o1_3, o2_3, o3_3}, prev3);
      mon(1, en5, done5, {o1_5, o2_5, o3_5}, prev5);
      prev3 <= en3;
      prev5 <= en5;
    end else begin
      prev3 <= 1'b0;
      prev5 <= 1'b0;
    end
  end

  task automatic end_frame(input bit err_exp);
    logic [18:0] s;
    for (int k = 0; k < 10 && qsize() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain", qsize(), 0);
    s = outs_sel();
    check("error_flag", {31'd0, s[0]}, {31'd0, err_exp});
    check("in_ready_after_frame", {31'd0, s[18]}, 32'd0);
  endtask

  task automatic run_frame(input int h, input bit fill_gaps, input int gap_idx,
                           input int abort_idx, input bit start_mid);
    exp_t e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < W; c++) begin
        int idx;
        idx = r * W + c;
        if (r < 2 && fill_gaps) begin
          repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        if (idx == abort_idx) begin
          in_valid = 1'b0;
          #5;
          reset_n = 1'b0;
          #1;
          check("async_reset_outputs", outs_sel(), 0);
          q3.delete();
          q5.delete();
          @(posedge clk); #1;
          reset_n = 1'b1;
          repeat (3) @(posedge clk);
          #1;
          check("after_reset_idle", outs_sel(), 0);
          return;
        end
        if (idx == gap_idx) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
          repeat (2) begin
            pixel_in = 5'($urandom);
            in_valid = 1'b1;
            @(posedge clk); #1;
          end
          in_valid = 1'b0;
          end_frame(1'b1);
          return;
        end
        pixel_in = pix[r][c];
        in_valid = 1'b1;
        check("in_ready_during_frame", {31'd0, outs_sel() >> 18}, 32'd1);
        if (start_mid && r == 2 && c == 0) start = 1'b1;
        if (r >= 2) begin
          e = '{a: pix[r-2][c], b: pix[r-1][c], c: pix[r][c], last: (r == h - 1 && c == W - 1)};
          if (sel == 0) q3.push_back(e);
          else          q5.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    end_frame(1'b0);
  endtask

  task automatic fill_seq();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W; c++) pix[r][c] = 5'(4 * r + c);
  endtask

  initial begin
    #12;
    sel = 0;
    check("reset_state_h3", outs_sel(), 0);
    sel = 1;
    check("reset_state_h5", outs_sel(), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    sel = 0;
    fill_seq();
    run_frame(3, 1'b0, -1, -1, 1'b0);
    run_frame(3, 1'b0, 9, -1, 1'b0);
    run_frame(3, 1'b1, -1, -1, 1'b0);
    run_frame(3, 1'b0, -1, -1, 1'b1);
    run_frame(3, 1'b0, -1, -1, 1'b0);
    run_frame(3, 1'b0, -1, 10, 1'b0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W; c++) pix[r][c] = 5'd31;
    run_frame(3, 1'b0, -1, -1, 1'b0);

    sel = 1;
    fill_seq();
    run_frame(5, 1'b0, -1, -1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int h, gap;
      sel = int'($urandom_range(0, 1));
      h = (sel == 0) ? 3 : 5;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < W; c++) pix[r][c] = 5'($urandom);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2 * W, h * W - 1)) : -1;
      run_frame(h, 1'($urandom), gap, -1, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
